fifo_read_prefetch: RTL and testbench

- Read-side controller for the dual-clock FIFO memory. It owns the read pointer, the gray-coded pointer exported to the write domain, and the empty flag.
- It drains the memory's asynchronous read port into a 2-entry prefetch buffer. The buffer presents first-word-fall-through data on a valid/ready interface.
- Sits entirely in the read clock domain, between the write-pointer synchronizer and the downstream consumer.

---
 rtl/async_fifo_pkg.sv | 11 +
 rtl/fifo_out_buf.sv | 58 +++++
 rtl/fifo_read_prefetch.sv | 68 ++++++
 tb/tb_fifo_read_prefetch.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Shared definitions for the dual-clock FIFO: pointer sizing and gray-code conversion.
package async_fifo_pkg;

    localparam int ADDRSIZE_DEF = 4;
    localparam int PTRSIZE      = ADDRSIZE_DEF + 1;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/fifo_out_buf.sv
// Two-entry first-word-fall-through buffer; entry 0 is always the head.
module fifo_out_buf #(
    parameter int DATASIZE = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [DATASIZE-1:0] push_data,
    input  logic                pop,
    output logic [1:0]          count,
    output logic [DATASIZE-1:0] head,
    output logic                valid
);

    logic [1:0]          r_count;
    logic [DATASIZE-1:0] r_e0;
    logic [DATASIZE-1:0] r_e1;
    logic                w_pop;
    logic                w_push;

    assign w_pop  = pop && (r_count != 2'd0);
    assign w_push = push && (r_count != 2'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 2'd0;
            r_e0    <= '0;
            r_e1    <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b11: begin
                    // Simultaneous push/pop: new word lands behind whatever stays at the head.
                    if (r_count == 2'd1) begin
                        r_e0 <= push_data;
                    end else begin
                        r_e0 <= r_e1;
                        r_e1 <= push_data;
                    end
                end
                2'b01: begin
                    r_e0    <= r_e1;
                    r_count <= r_count - 2'd1;
                end
                2'b10: begin
                    if (r_count == 2'd0) r_e0 <= push_data;
                    else                 r_e1 <= push_data;
                    r_count <= r_count + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign count = r_count;
    assign head  = r_e0;
    assign valid = (r_count != 2'd0);

endmodule

// File: rtl/fifo_read_prefetch.sv
// Read-side FIFO controller: read pointer, gray pointer export, empty flag, FWFT prefetch.
module fifo_read_prefetch
    import async_fifo_pkg::*;
#(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = ADDRSIZE_DEF
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    output logic [ADDRSIZE-1:0] raddr,
    input  logic [DATASIZE-1:0] mem_rdata,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic                rvalid,
    input  logic                rready,
    output logic [DATASIZE-1:0] rdata
);

    localparam int PW = ADDRSIZE + 1;

    logic [PW-1:0] r_rbin;
    logic [PW-1:0] r_rptr;
    logic          r_rempty;
    logic [PW-1:0] w_rbinnext;
    logic [PW-1:0] w_rgraynext;
    logic [1:0]    w_count;
    logic          w_fetch;
    logic          w_pop;
    logic          w_valid;

    // Fetch looks only at registered state, never at rready.
    assign w_fetch     = !r_rempty && (w_count < 2'd2);
    assign w_pop       = w_valid && rready;
    assign w_rbinnext  = r_rbin + PW'(w_fetch);
    assign w_rgraynext = PW'(bin2gray(32'(w_rbinnext)));

    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_rbin   <= '0;
            r_rptr   <= '0;
            r_rempty <= 1'b1;
        end else begin
            r_rbin   <= w_rbinnext;
            r_rptr   <= w_rgraynext;
            r_rempty <= (w_rgraynext == rq2_wptr);
        end
    end

    fifo_out_buf #(
        .DATASIZE (DATASIZE)
    ) u_out_buf (
        .clk       (rclk),
        .rst       (rrst),
        .push      (w_fetch),
        .push_data (mem_rdata),
        .pop       (w_pop),
        .count     (w_count),
        .head      (rdata),
        .valid     (w_valid)
    );

    assign raddr  = r_rbin[ADDRSIZE-1:0];
    assign rptr   = r_rptr;
    assign rempty = r_rempty;
    assign rvalid = w_valid;

endmodule

// File: tb/tb_fifo_read_prefetch.sv
// Scoreboard bench for fifo_read_prefetch with a simple write-side memory model.
module tb_fifo_read_prefetch;

    logic       rclk = 1'b0;
    logic       rrst = 1'b1;
    logic [4:0] rq2_wptr = '0;
    logic [3:0] raddr;
    logic [7:0] mem_rdata;
    logic [4:0] rptr;
    logic       rempty;
    logic       rvalid;
    logic       rready = 1'b0;
    logic [7:0] rdata;

    logic [7:0] mem [16];
    logic [7:0] exp_q [$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         wtot = 0;
    int         popped = 0;
    bit         seen18 = 0;
    bit         seen00 = 0;
    bit         done = 0;

    always #5 rclk = ~rclk;

    assign mem_rdata = mem[raddr];

    fifo_read_prefetch #(.DATASIZE(8), .ADDRSIZE(4)) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .rq2_wptr  (rq2_wptr),
        .raddr     (raddr),
        .mem_rdata (mem_rdata),
        .rptr      (rptr),
        .rempty    (rempty),
        .rvalid    (rvalid),
        .rready    (rready),
        .rdata     (rdata)
    );

    function automatic logic [4:0] gray5(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic write_word(input logic [7:0] d);
        logic [31:0] w;
        mem[wtot % 16] = d;
        wtot++;
        w = wtot;
        rq2_wptr = gray5(w[4:0]);
        exp_q.push_back(d);
    endtask

    task automatic do_reset();
        rrst = 1'b1;
        rready = 1'b0;
        wtot = 0;
        popped = 0;
        rq2_wptr = '0;
        exp_q.delete();
        @(posedge rclk); #1;
        @(posedge rclk); #1;
        rrst = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge rclk); #1;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    // Consumer side: every accepted word must match the scoreboard head.
    always @(negedge rclk) begin
        if (!rrst && rvalid && rready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_word", {31'd0, rvalid}, 0);
            end else begin
                chk("data", {24'd0, rdata}, {24'd0, exp_q.pop_front()});
                popped++;
            end
        end
        if (rptr == 5'h18) seen18 = 1;
        if (seen18 && rptr == 5'h00) seen00 = 1;
    end

    initial begin
        int cnt;
        for (int i = 0; i < 16; i++) mem[i] = '0;

        // Reset, then idle with nothing written.
        do_reset();
        repeat (5) begin
            chk("idle_rempty", {31'd0, rempty}, 1);
            chk("idle_rvalid", {31'd0, rvalid}, 0);
            chk("idle_rptr", {27'd0, rptr}, 0);
            @(posedge rclk); #1;
        end

        // Single word latency.
        do_reset();
        rready = 1'b1;
        @(posedge rclk); #1;
        write_word(8'hA1);
        @(posedge rclk); #1;
        chk("one_rempty_n1", {31'd0, rempty}, 0);
        chk("one_rvalid_n1", {31'd0, rvalid}, 0);
        @(posedge rclk); #1;
        chk("one_rvalid_n2", {31'd0, rvalid}, 1);
        chk("one_rdata_n2", {24'd0, rdata}, 32'hA1);
        chk("one_rptr", {27'd0, rptr}, 1);
        chk("one_rempty_n2", {31'd0, rempty}, 1);
        @(posedge rclk); #1;
        chk("one_rvalid_after", {31'd0, rvalid}, 0);
        chk("one_popped", popped, 1);

        // Full memory streamed at one word per cycle.
        do_reset();
        rready = 1'b1;
        for (int i = 0; i < 16; i++) write_word(i[7:0]);
        chk("full_wptr", {27'd0, rq2_wptr}, 32'h18);
        for (int i = 0; i < 20; i++) begin
            @(negedge rclk);
            if (rvalid) break;
        end
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (rvalid && rready) cnt++;
            @(negedge rclk);
        end
        chk("full_rate", cnt, 16);
        @(posedge rclk); #1;
        chk("full_rptr", {27'd0, rptr}, 32'h18);
        chk("full_rempty", {31'd0, rempty}, 1);
        chk("full_rvalid", {31'd0, rvalid}, 0);
        chk("full_left", exp_q.size(), 0);

        // Backpressure: buffer fills to two, head holds.
        do_reset();
        for (int i = 0; i < 16; i++) write_word(i[7:0]);
        for (int i = 0; i < 10; i++) begin
            @(posedge rclk); #1;
            if (i >= 4) begin
                chk("bp_rvalid", {31'd0, rvalid}, 1);
                chk("bp_rdata", {24'd0, rdata}, 0);
            end
        end
        chk("bp_raddr", {28'd0, raddr}, 2);
        chk("bp_rptr", {27'd0, rptr}, {27'd0, gray5(5'd2)});
        chk("bp_rempty", {31'd0, rempty}, 0);
        rready = 1'b1;
        drain(100);
        chk("bp_popped", popped, 16);

        // Wrap through the pointer space with random backpressure.
        do_reset();
        seen18 = 0;
        seen00 = 0;
        done = 0;
        fork
            begin
                while (!done && wtot < 40) begin
                    @(posedge rclk); #1;
                    if (wtot - popped < 16) write_word(8'($urandom_range(0, 255)));
                end
            end
            begin
                while (!done) begin
                    @(posedge rclk); #1;
                    rready = 1'($urandom_range(0, 1));
                end
            end
        join_none
        for (int i = 0; i < 3000; i++) begin
            if (popped == 40) break;
            @(posedge rclk);
        end
        done = 1;
        chk("wrap_popped", popped, 40);
        repeat (2) @(posedge rclk);
        #1;
        rready = 1'b1;
        @(posedge rclk); #1;
        chk("wrap_seen18", {31'd0, seen18}, 1);
        chk("wrap_seen00", {31'd0, seen00}, 1);
        chk("wrap_rptr", {27'd0, rptr}, {27'd0, gray5(5'd8)});
        chk("wrap_rempty", {31'd0, rempty}, 1);

        // Reset in the middle of a stalled burst.
        do_reset();
        for (int i = 0; i < 16; i++) write_word(8'h40 + i[7:0]);
        repeat (5) begin
            @(posedge rclk); #1;
        end
        chk("mid_rvalid_pre", {31'd0, rvalid}, 1);
        rrst = 1'b1;
        wtot = 0;
        popped = 0;
        rq2_wptr = '0;
        exp_q.delete();
        @(posedge rclk); #1;
        chk("mid_rvalid", {31'd0, rvalid}, 0);
        chk("mid_rptr", {27'd0, rptr}, 0);
        chk("mid_rempty", {31'd0, rempty}, 1);
        rrst = 1'b0;
        rready = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(posedge rclk); #1;
            if (rvalid) cnt++;
        end
        chk("mid_no_stale", cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
